ram_arbiter: RTL

Two-requester round-robin arbiter sharing one single-port synchronous RAM (cen/wen/s_addr/s_din/s_dout interface).
- Accepts read/write commands from masters m0 and m1 with a req/gnt handshake.
- Drives registered RAM control.
- Returns read data to the issuing master with a read-valid pulse.
- Sits between the two datapath clients and the RAM instance.

---
 rtl/ram_ctrl_pkg.sv | 20 ++
 rtl/ram_arbiter_if.sv | 50 +++++
 rtl/ram_arbiter_rr_arb2.sv | 40 ++++
 rtl/ram_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the two-master RAM arbiter: default bus widths,
// requester identifiers and the read-return pipeline stage record.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 64;

  // Requester identity, also used as the round-robin priority pointer.
  typedef enum logic {
    ID_M0 = 1'b0,
    ID_M1 = 1'b1
  } req_id_t;

  // One stage of the read-return tracking pipeline.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_stage_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two master command/return channels and the RAM-side bus.
// slave  : view taken by the arbiter (receives commands and s_dout,
//          drives grants, read returns and RAM control).
// master : view taken by the clients and the RAM (the opposite directions).
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = ram_ctrl_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = ram_ctrl_pkg::DATA_W_DEF
);

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              cen;
  logic              wen;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  s_dout,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output cen, wen, s_addr, s_din
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output s_dout,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  cen, wen, s_addr, s_din
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin grant with its priority pointer flop.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req[1:0] : request per master (bit 0 = m0, bit 1 = m1)
//   o_gnt_c    : one-hot (or zero) grant, combinational from i_req and pointer
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt_c
);

  req_id_t r_ptr;
  req_id_t w_ptr_nxt;

  // Grant selection; after any grant the pointer favours the other master.
  always_comb begin
    o_gnt_c   = 2'b00;
    w_ptr_nxt = r_ptr;
    if (i_req[0] && (!i_req[1] || (r_ptr == ID_M0))) begin
      o_gnt_c   = 2'b01;
      w_ptr_nxt = ID_M1;
    end else if (i_req[1]) begin
      o_gnt_c   = 2'b10;
      w_ptr_nxt = ID_M0;
    end
  end

  // Priority pointer; m0 is favoured out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= ID_M0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter letting two masters share one single-port synchronous
// RAM. Accepted commands are registered onto the RAM bus; reads are tracked
// through a two-stage pipeline so the issuing master gets an rvalid pulse
// aligned with s_dout two cycles after its accept edge.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : master command/grant/read-return channels and RAM bus
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  ram_arbiter_if.slave  bus
);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_accept;
  req_id_t           w_sel_id;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  logic              r_cen;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  rd_stage_t         r_rd1;
  logic [1:0]        r_rvalid;

  assign w_req = {bus.m1_req, bus.m0_req};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_req   (w_req),
    .o_gnt_c (w_gnt)
  );

  // Mux the granted master's command onto the issue path.
  always_comb begin
    w_accept = |w_gnt;
    w_sel_id = w_gnt[1] ? ID_M1 : ID_M0;
    w_we     = w_gnt[1] ? bus.m1_we    : bus.m0_we;
    w_addr   = w_gnt[1] ? bus.m1_addr  : bus.m0_addr;
    w_wdata  = w_gnt[1] ? bus.m1_wdata : bus.m0_wdata;
  end

  // Issue stage: address/data hold when idle so the RAM bus stays quiet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cen  <= 1'b0;
      r_wen  <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_accept) begin
      r_cen  <= 1'b1;
      r_wen  <= w_we;
      r_addr <= w_addr;
      r_din  <= w_wdata;
    end else begin
      r_cen  <= 1'b0;
      r_wen  <= 1'b0;
    end
  end

  // Read-return pipeline: stage 1 marks the RAM sampling cycle, stage 2
  // lines up with s_dout and is decoded per master. Reset drops in-flight reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd1    <= '{valid: 1'b0, id: ID_M0};
      r_rvalid <= 2'b00;
    end else begin
      r_rd1    <= '{valid: w_accept & ~w_we, id: w_sel_id};
      r_rvalid <= {r_rd1.valid & (r_rd1.id == ID_M1),
                   r_rd1.valid & (r_rd1.id == ID_M0)};
    end
  end

  assign bus.m0_gnt    = w_gnt[0];
  assign bus.m1_gnt    = w_gnt[1];
  assign bus.m0_rvalid = r_rvalid[0];
  assign bus.m1_rvalid = r_rvalid[1];
  assign bus.m0_rdata  = bus.s_dout;
  assign bus.m1_rdata  = bus.s_dout;
  assign bus.cen       = r_cen;
  assign bus.wen       = r_wen;
  assign bus.s_addr    = r_addr;
  assign bus.s_din     = r_din;

endmodule
